// File: rtl/vlc_pkg.sv
// Shared constants, the reader state type and a small occupancy helper
// for the RAM frame reader.
package vlc_pkg;

  localparam int RAM_DEPTH = 1024;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rdr_state_e;

  // Bytes that will be held once this cycle's pop completes: the buffered
  // bytes plus the one read still on its way back from the RAM.
  function automatic logic [2:0] occupancy(input logic [1:0] count,
                                           input logic       in_flight,
                                           input logic       pop);
    occupancy = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/byte_skid_fifo.sv
// Two-entry byte FIFO with a per-byte last flag. The head entry is driven
// straight out of storage so it stays put while the consumer stalls.
module byte_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        last_q;
  logic [1:0]        last_d;
  logic              wr_ptr_q;
  logic              wr_ptr_d;
  logic              rd_ptr_q;
  logic              rd_ptr_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  // Next-state for storage, pointers and fill level.
  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q]  = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset leaves the FIFO empty with zeroed storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= {DATA_W{1'b0}};
      mem_q[1] <= {DATA_W{1'b0}};
      last_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign data  = mem_q[rd_ptr_q];
  assign last  = last_q[rd_ptr_q] & (count_q != 2'd0);

endmodule

// File: rtl/ram_frame_reader.sv
// Streams a frame of bytes out of a synchronous-read RAM: a run of
// consecutive (wrapping) addresses is read and forwarded through a
// two-entry FIFO as a valid/ready byte stream with a last marker.
module ram_frame_reader
  import vlc_pkg::*;
#(
  parameter int ADDR_W = vlc_pkg::ADDR_W,
  parameter int DATA_W = vlc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int CNT_W = ADDR_W + 1;

  rdr_state_e        state_q;
  rdr_state_e        state_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  len_d;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  rd_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              inflight_q;
  logic              inflight_d;
  logic              inflight_last_q;
  logic              inflight_last_d;

  logic [1:0]        fifo_count_s;
  logic              fifo_valid_s;
  logic              fifo_last_s;
  logic              pop_s;
  logic              last_rd_s;

  assign fifo_valid_s = (fifo_count_s != 2'd0);
  assign pop_s        = fifo_valid_s & m_ready;
  assign last_rd_s    = (rd_cnt_q == (len_q - CNT_W'(1)));

  // Sequencing: capture a request, issue reads while the FIFO has room
  // counting the read in flight, then wait for the last byte to leave.
  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    len_d           = len_q;
    rd_cnt_d        = rd_cnt_q;
    addr_d          = addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != CNT_W'(0)) begin
            state_d  = ST_RUN;
            busy_d   = 1'b1;
            len_d    = length;
            rd_cnt_d = CNT_W'(0);
            addr_d   = base_addr;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (occupancy(fifo_count_s, inflight_q, pop_s) < 3'd2) begin
          inflight_d      = 1'b1;
          inflight_last_d = last_rd_s;
          addr_d          = addr_q + ADDR_W'(1);
          rd_cnt_d        = rd_cnt_q + CNT_W'(1);
          if (last_rd_s) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (pop_s && fifo_last_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller registers; reset aborts any frame and drops the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      len_q           <= CNT_W'(0);
      rd_cnt_q        <= CNT_W'(0);
      addr_q          <= ADDR_W'(0);
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      len_q           <= len_d;
      rd_cnt_q        <= rd_cnt_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  byte_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_dout),
    .push_last (inflight_last_q),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .data      (m_data),
    .last      (fifo_last_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign ram_we   = 1'b0;
  assign m_valid  = fifo_valid_s;
  assign m_last   = fifo_last_s;

endmodule

// File: tb/tb_ram_frame_reader.sv
// Self-checking bench for ram_frame_reader: a synchronous-read RAM model,
// directed frames for the documented corner cases and random frames, all
// checked against an expected byte list built from the RAM contents.
module tb_ram_frame_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;

  logic [7:0]  ram [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  ram_frame_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data appears one clock after the address.
  always @(posedge clk) ram_dout <= ram[ram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int pct);
    return (int'($urandom_range(0, 99)) < pct);
  endfunction

  // One frame: request it, then walk cycle by cycle at the falling edge,
  // comparing the stream with the expected byte list.
  task automatic run_frame(input logic [9:0] b, input logic [10:0] l,
                           input int rdy_pct, input bit poke);
    logic [7:0] exp_q[$];
    int         idx;
    int         dones;
    bit         done_due;
    bit         finished;
    bit         stalled;
    logic [7:0] prev_d;
    logic       prev_l;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(ram[(int'(b) + i) % 1024]);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    m_ready   = pick_ready(rdy_pct);
    @(negedge clk);
    start     = 1'b0;
    base_addr = 10'($urandom);
    length    = 11'($urandom_range(0, 1024));
    idx = 0; dones = 0; done_due = (l == 11'd0); finished = 1'b0; stalled = 1'b0;
    prev_d = 8'd0; prev_l = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      chk("done", {31'd0, done}, {31'd0, done_due});
      if (done) dones++;
      chk("ram_we", {31'd0, ram_we}, 32'd0);
      if (done_due) begin
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("valid_end", {31'd0, m_valid}, 32'd0);
        finished = 1'b1;
        break;
      end
      chk("busy", {31'd0, busy}, 32'd1);
      if (k < 2) chk("valid_latency", {31'd0, m_valid}, 32'd0);
      else if (k == 2 || rdy_pct == 100) chk("valid_nobubble", {31'd0, m_valid}, 32'd1);
      if (m_valid) begin
        if (stalled) begin
          chk("stall_data", {24'd0, m_data}, {24'd0, prev_d});
          chk("stall_last", {31'd0, m_last}, {31'd0, prev_l});
        end
        chk("data", {24'd0, m_data}, {24'd0, exp_q[idx]});
        chk("last", {31'd0, m_last}, {31'd0, (idx == int'(l) - 1)});
      end
      start = poke && (k == 3);
      if (start) begin
        base_addr = 10'($urandom);
        length    = 11'($urandom_range(1, 1024));
      end
      m_ready = pick_ready(rdy_pct);
      stalled = m_valid && !m_ready;
      prev_d  = m_data;
      prev_l  = m_last;
      if (m_valid && m_ready) begin
        idx++;
        if (idx == int'(l)) done_due = 1'b1;
      end
      @(negedge clk);
    end
    chk("frame_timeout", {31'd0, finished}, 32'd1);
    start   = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("done_count", dones, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 10'd0; length = 11'd0; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, busy},    32'd0);
    chk("rst_done",   {31'd0, done},    32'd0);
    chk("rst_valid",  {31'd0, m_valid}, 32'd0);
    chk("rst_last",   {31'd0, m_last},  32'd0);
    chk("rst_addr",   {22'd0, ram_addr}, 32'd0);
    chk("rst_data",   {24'd0, m_data},  32'd0);
    rst_n = 1'b1;

    // Directed frames on the identity RAM image.
    run_frame(10'h010, 11'd4, 100, 1'b0);
    run_frame(10'h3FE, 11'd4, 100, 1'b0);
    run_frame(10'h123, 11'd8, 50, 1'b0);
    run_frame(10'h055, 11'd0, 100, 1'b0);
    run_frame(10'h2A7, 11'd1, 100, 1'b0);
    run_frame(10'h300, 11'd12, 70, 1'b1);
    run_frame(10'h1F0, 11'd1024, 100, 1'b0);

    // Reset in the middle of a 16-byte frame, then a fresh short frame.
    @(negedge clk);
    start = 1'b1; base_addr = 10'h200; length = 11'd16; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_midframe_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  {31'd0, busy},    32'd0);
    chk("abort_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_addr",  {22'd0, ram_addr}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_valid_after", {31'd0, m_valid}, 32'd0);
    chk("abort_done_after",  {31'd0, done},    32'd0);
    run_frame(10'h100, 11'd2, 100, 1'b0);

    // Random RAM image and random frames.
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int f = 0; f < 12; f++) begin
      run_frame(10'($urandom), 11'($urandom_range(1, 48)),
                (f % 3 == 0) ? 100 : int'($urandom_range(20, 90)), (f % 4 == 1));
    end
    run_frame(10'h3FF, 11'd3, 100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_frame_reader.md
RAM_FRAME_READER -- requirements
Module: ram_frame_reader

Interface
REQ-001 Parameter ADDR_W, 10, RAM address width (1024-byte frame buffer).
REQ-002 Parameter DATA_W, 8, RAM and stream byte width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to stream a frame; sampled only when busy=0.
REQ-006 base_addr  input  ADDR_W  first RAM address of frame; captured with start.
REQ-007 length  input  ADDR_W+1  byte count, 0..1024; captured with start.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse at frame completion.
REQ-010 ram_addr  output  ADDR_W  read address to the RAM.
REQ-011 ram_we  output  1  RAM write enable; constant 0.
REQ-012 ram_dout  input  DATA_W  RAM read data, valid one clock after ram_addr is presented.
REQ-013 m_valid / m_data[DATA_W-1:0] / m_last  output  byte stream; m_last marks final byte.
REQ-014 m_ready  input  1  downstream accept; beat transfers when m_valid and m_ready are both 1.

Function
REQ-015 States: IDLE, RUN, FLUSH; busy=1 in RUN and FLUSH.
REQ-016 IDLE->RUN on start with length!=0; base_addr and length are captured at that edge.
REQ-017 start with length=0 in IDLE: no beats; done pulses at the next edge; state stays IDLE.
REQ-018 start while busy=1 is ignored.
REQ-019 Reads are issued in RUN at consecutive addresses base_addr+i mod 1024 (wrap from 1023 to 0), i=0..length-1.
REQ-020 A read is issued only when buffered bytes plus the in-flight read total < 2; data never drops under backpressure.
REQ-021 Output is buffered in a 2-entry FIFO; bytes leave in address order.
REQ-022 Latency: start sampled at edge N -> m_valid=1 with byte of base_addr from edge N+2.
REQ-023 Throughput: with m_ready held 1, one beat per clock, no bubbles, including across address wrap.
REQ-024 m_data and m_last remain stable while m_valid=1 and m_ready=0.
REQ-025 m_last=1 only on beat length-1; for length=1 the single beat has m_last=1.
REQ-026 RUN->FLUSH after the last read issues; FLUSH->IDLE on the m_last handshake edge, where done=1 for exactly one cycle and busy drops.
REQ-027 length values above 1024 cannot occur (width-limited); length=1024 reads every address exactly once.
REQ-028 Counters are ADDR_W+1 bits wide and compare against the captured length; the address counter is ADDR_W bits and wraps naturally.

Reset
REQ-029 rst_n=0 forces IDLE; busy, done, m_valid, m_last = 0; ram_addr, m_data = 0; FIFO empty.
REQ-030 Reset mid-frame aborts it: the in-flight read is discarded, no done pulse; first start after release behaves as REQ-022.

Structure
REQ-031 Shared package vlc_pkg holds RAM_DEPTH=1024, ADDR_W, DATA_W and the reader state enum.
REQ-032 The 2-entry FIFO is sub-module byte_skid_fifo (push, pop, count[1:0], data, last flag).

Verification
REQ-033 RAM preloaded ram[i]=i[7:0]; start base=0x010 len=4, m_ready=1 -> bytes 0x10,0x11,0x12,0x13 on edges N+2..N+5, m_last on 0x13, done at N+6.
REQ-034 base=0x3FE len=4 -> bytes 0xFE,0xFF,0x00,0x01 (addresses 0x3FE,0x3FF,0x000,0x001), no bubble at wrap.
REQ-035 len=8, m_ready toggling 1,0,0,1 pseudo-randomly -> all 8 bytes in order, none duplicated or lost, data stable while stalled.
REQ-036 len=0 -> no m_valid, done pulse one cycle after start; len=1 -> single beat with m_last=1.
REQ-037 rst_n low during beat 3 of len=16, then start base=0x100 len=2 -> only 0x00,0x01 streamed, single done.
REQ-038 start re-asserted while busy -> ignored; current frame and done count unchanged.
